// File: rtl/moore_ser_tx.sv
// Moore serial frame transmitter: start bit, WIDTH data bits MSB-first,
// optional parity bit, stop bit. Every output comes straight from a register.
module moore_ser_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYC    = 1,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] Data,
  output logic             Dout,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [7:0]    CYC_LAST = 8'(BIT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bit;
  logic [7:0]       r_cyc;
  logic             r_par;
  logic             r_dout;
  logic             r_done;

  state_t           w_state_nx;
  logic [WIDTH-1:0] w_shreg_nx;
  logic [BW-1:0]    w_bit_nx;
  logic [7:0]       w_cyc_nx;
  logic             w_par_nx;
  logic             w_dout_nx;
  logic             w_done_nx;
  logic             w_bound;

  assign w_bound = (r_cyc == CYC_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_shreg_nx = r_shreg;
    w_bit_nx   = r_bit;
    w_cyc_nx   = r_cyc;
    w_par_nx   = r_par;
    w_done_nx  = 1'b0;

    if (r_state == S_IDLE) begin
      // The done cycle is an ordinary IDLE cycle, so a load here starts the next frame.
      if (load) begin
        w_state_nx = S_START;
        w_shreg_nx = Data;
        w_par_nx   = (^Data) ^ (PARITY_ODD != 0);
        w_bit_nx   = '0;
        w_cyc_nx   = '0;
      end
    end else if (!w_bound) begin
      w_cyc_nx = r_cyc + 8'd1;
    end else begin
      w_cyc_nx = '0;
      case (r_state)
        S_START: w_state_nx = S_DATA;
        S_DATA: begin
          w_shreg_nx = {r_shreg[WIDTH-2:0], 1'b0};
          if (r_bit == LAST_BIT) begin
            w_state_nx = (PARITY_EN != 0) ? S_PAR : S_STOP;
            w_bit_nx   = '0;
          end else begin
            w_bit_nx = r_bit + 1'b1;
          end
        end
        S_PAR:  w_state_nx = S_STOP;
        S_STOP: begin
          w_state_nx = S_IDLE;
          w_done_nx  = 1'b1;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end

    // Line level is chosen from the state being entered so it changes with the state.
    case (w_state_nx)
      S_START: w_dout_nx = 1'b1;
      S_DATA:  w_dout_nx = w_shreg_nx[WIDTH-1];
      S_PAR:   w_dout_nx = w_par_nx;
      default: w_dout_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_bit   <= '0;
      r_cyc   <= '0;
      r_par   <= 1'b0;
      r_dout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_shreg <= w_shreg_nx;
      r_bit   <= w_bit_nx;
      r_cyc   <= w_cyc_nx;
      r_par   <= w_par_nx;
      r_dout  <= w_dout_nx;
      r_done  <= w_done_nx;
    end
  end

  assign Dout = r_dout;
  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_moore_ser_tx.sv
// Bench for moore_ser_tx: four instances cover default, odd parity, no parity
// and BIT_CYC=3; a per-cycle vector table plus directed multi-cycle sequences.
module tb_moore_ser_tx;

  logic       clk;
  logic       rst;
  logic       load_v [4];
  logic [7:0] data_v [4];
  logic       dout_v [4];
  logic       busy_v [4];
  logic       done_v [4];

  int n_checks;
  int n_fail;

  typedef struct {
    logic       rst;
    logic       load;
    logic [7:0] data;
    logic       dout;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  moore_ser_tx #(.WIDTH(8), .BIT_CYC(1), .PARITY_EN(1), .PARITY_ODD(0)) u_def (
    .clk(clk), .rst(rst), .load(load_v[0]), .Data(data_v[0]),
    .Dout(dout_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  moore_ser_tx #(.WIDTH(8), .BIT_CYC(1), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .load(load_v[1]), .Data(data_v[1]),
    .Dout(dout_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  moore_ser_tx #(.WIDTH(8), .BIT_CYC(1), .PARITY_EN(0), .PARITY_ODD(0)) u_nop (
    .clk(clk), .rst(rst), .load(load_v[2]), .Data(data_v[2]),
    .Dout(dout_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  moore_ser_tx #(.WIDTH(8), .BIT_CYC(3), .PARITY_EN(1), .PARITY_ODD(0)) u_slow (
    .clk(clk), .rst(rst), .load(load_v[3]), .Data(data_v[3]),
    .Dout(dout_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic l, input logic [7:0] d,
                     input logic o, input logic b, input logic n);
    vec_t v;
    v.rst = r; v.load = l; v.data = d; v.dout = o; v.busy = b; v.done = n;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int d,
                         input logic o, input logic b, input logic n);
    chk({tag, " dout"}, dout_v[d], o);
    chk({tag, " busy"}, busy_v[d], b);
    chk({tag, " done"}, done_v[d], n);
  endtask

  // Sends one frame on instance d and checks every cycle through the done cycle.
  // hold keeps load high throughout; junk scrambles load/Data while busy.
  task automatic send_frame(input string tag, input int d, input logic [7:0] data,
                            input int bc, input bit pe, input bit po,
                            input bit hold, input bit junk);
    logic exp_q[$];
    logic p;
    p = (^data) ^ po;
    exp_q.push_back(1'b1);
    for (int i = 7; i >= 0; i--) exp_q.push_back(data[i]);
    if (pe) exp_q.push_back(p);
    exp_q.push_back(1'b0);

    data_v[d] = data;
    load_v[d] = 1'b1;
    for (int b = 0; b < exp_q.size(); b++) begin
      for (int c = 0; c < bc; c++) begin
        if (b != 0 || c != 0) begin
          if (junk) begin
            load_v[d] = 1'($urandom_range(0, 1));
            data_v[d] = 8'($urandom_range(0, 255));
          end else if (!hold) begin
            load_v[d] = 1'b0;
          end
        end
        step();
        chk_out($sformatf("%s bit%0d cyc%0d", tag, b, c), d, exp_q[b], 1'b1, 1'b0);
      end
    end
    load_v[d] = hold;
    step();
    chk_out({tag, " done_cycle"}, d, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_v[i] = 1'b0;
      data_v[i] = 8'h00;
    end

    // Reset, idle, A5 frame, then 07 frame with load/Data churn mid-frame
    add(1, 0, 8'h00, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'hA5, 1, 1, 0);
    add(0, 0, 8'h00, 1, 1, 0);
    add(0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 0);
    add(0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 0);
    add(0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 0);
    add(0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'h07, 1, 1, 0);
    add(0, 1, 8'hFF, 0, 1, 0);
    add(0, 0, 8'hAA, 0, 1, 0);
    add(0, 1, 8'h00, 0, 1, 0);
    add(0, 0, 8'h55, 0, 1, 0);
    add(0, 1, 8'hFF, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 0);
    add(0, 1, 8'h80, 1, 1, 0);
    add(0, 0, 8'h00, 1, 1, 0);
    add(0, 1, 8'hFF, 1, 1, 0);
    add(0, 1, 8'hFF, 0, 1, 0);
    add(0, 1, 8'h3C, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      load_v[0] = vecs[i].load;
      data_v[0] = vecs[i].data;
      step();
      chk_out($sformatf("vec%0d", i), 0, vecs[i].dout, vecs[i].busy, vecs[i].done);
    end
    load_v[0] = 1'b0;

    for (int d = 1; d < 4; d++) chk_out($sformatf("idle_inst%0d", d), d, 1'b0, 1'b0, 1'b0);

    // Odd parity: 07 has three ones, so parity bit is 0
    send_frame("odd_07", 1, 8'h07, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("odd_after", 1, 1'b0, 1'b0, 1'b0);

    // No parity: 10-bit frame, done 11 cycles after accept
    send_frame("nop_07", 2, 8'h07, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("nop_after", 2, 1'b0, 1'b0, 1'b0);

    // BIT_CYC=3 with load/Data scrambled during the frame
    send_frame("slow_80", 3, 8'h80, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("slow_after", 3, 1'b0, 1'b0, 1'b0);

    // Back-to-back with load held high
    send_frame("b2b_3C", 0, 8'h3C, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame("b2b_C3", 0, 8'hC3, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("b2b_after", 0, 1'b0, 1'b0, 1'b0);

    // Reset during the 5th data bit of 5A (bits 0,1,0,1,1 seen so far)
    data_v[0] = 8'h5A;
    load_v[0] = 1'b1;
    step();
    chk_out("rst_start", 0, 1'b1, 1'b1, 1'b0);
    load_v[0] = 1'b0;
    step(); chk("rst_d7", dout_v[0], 1'b0);
    step(); chk("rst_d6", dout_v[0], 1'b1);
    step(); chk("rst_d5", dout_v[0], 1'b0);
    step(); chk("rst_d4", dout_v[0], 1'b1);
    step(); chk("rst_d3", dout_v[0], 1'b1);
    rst = 1'b1;
    step();
    chk_out("rst_abort", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk_out($sformatf("rst_quiet%0d", i), 0, 1'b0, 1'b0, 1'b0);
    end
    send_frame("post_rst_FF", 0, 8'hFF, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("post_rst_after", 0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
